// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small receive FIFO and sticky overflow/framing flags,
// presented to the CPU as one 16-bit status/data word.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 16
) (
    input  logic                      CLK_100MHz,
    input  logic                      RESET_N,
    input  logic                      CLK_CPU,
    input  logic                      UART_RX,
    input  logic                      RD,
    output logic [15:0]               DATA,
    output logic [$clog2(DEPTH):0]    COUNT
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    rx_state_t        state, state_next;
    logic             rx_meta, rx_sync, rx_prev;
    logic             fall, bit_tick, half_tick, stop_tick;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             push_req, ferr_set;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             ovf, ferr;
    logic             cpu_rd, fifo_empty, fifo_full, push, pop, ovf_set;

    // NOTE: synchronizer resets to the idle level so releasing reset cannot look like a start edge.
    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= UART_RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall      = rx_prev & ~rx_sync;
    assign bit_tick  = (clk_cnt == BIT_LAST);
    assign half_tick = (clk_cnt == HALF_LAST);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        stop_tick  = 1'b0;
        case (state)
            ST_IDLE:  if (fall) state_next = ST_START;
            ST_START: if (half_tick) state_next = rx_sync ? ST_IDLE : ST_DATA;
            ST_DATA:  if (bit_tick && bit_idx == 3'd7) state_next = ST_STOP;
            ST_STOP: begin
                if (bit_tick) begin
                    state_next = ST_IDLE;
                    stop_tick  = 1'b1;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            push_req  <= 1'b0;
            ferr_set  <= 1'b0;
        end else begin
            state <= state_next;
            // Period counter restarts on each state change and at every data-bit boundary.
            if (state_next != state || state == ST_IDLE || bit_tick)
                clk_cnt <= '0;
            else
                clk_cnt <= clk_cnt + CNT_W'(1);
            if (state == ST_IDLE && fall)
                bit_idx <= '0;
            if (state == ST_DATA && bit_tick) begin
                shift_reg <= {rx_sync, shift_reg[7:1]};
                bit_idx   <= bit_idx + 3'd1;
            end
            push_req <= stop_tick & rx_sync;
            ferr_set <= stop_tick & ~rx_sync;
        end
    end

    assign cpu_rd     = CLK_CPU & RD;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign pop        = cpu_rd & ~fifo_empty;
    assign push       = push_req & (~fifo_full | pop);
    assign ovf_set    = push_req & fifo_full & ~pop;

    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            ferr   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            ovf  <= ovf_set  | (ovf  & ~cpu_rd);
            ferr <= ferr_set | (ferr & ~cpu_rd);
        end
    end

    // NOTE: storage has no reset; the empty check below keeps stale entries invisible.
    always_ff @(posedge CLK_100MHz) begin
        if (push) mem[wr_ptr] <= shift_reg;
    end

    assign DATA  = {5'b0, ferr, ovf, ~fifo_empty, fifo_empty ? 8'h00 : mem[rd_ptr]};
    assign COUNT = count;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868; CLK_100MHz cycles per UART bit (115200 baud).
REQ-002 Parameter DEPTH, default 16; FIFO entries, power of two, 2..256.
REQ-003 CLK_100MHz  input  1  sole clock; all flops SHALL be clocked on its rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 CLK_CPU  input  1  CPU clock-enable pulse, high for one CLK_100MHz cycle per CPU step.
REQ-006 UART_RX  input  1  asynchronous serial line, idle high, 8N1.
REQ-007 RD  input  1  CPU read/pop request, qualified by CLK_CPU.
REQ-008 DATA  output  16  status/data word {5'b0, FERR, OVF, VALID, BYTE[7:0]}.
REQ-009 COUNT  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-010 UART_RX SHALL pass through a 2-flop synchronizer before any use; all timing below is relative to the synchronized line.
REQ-011 The receiver FSM SHALL have states IDLE, START, DATA, STOP.
REQ-012 IDLE -> START on a synchronized falling edge; the bit counter SHALL be cleared.
REQ-013 In START, the line SHALL be resampled after CLKS_PER_BIT/2 cycles: low -> DATA; high -> IDLE (glitch), with no push and no flag change.
REQ-014 In DATA, 8 bits SHALL be sampled LSB first, one every CLKS_PER_BIT cycles after the START midpoint.
REQ-015 STOP SHALL sample once, CLKS_PER_BIT cycles after bit 7. High -> push byte. Low -> discard byte and set FERR.
REQ-016 After the STOP sample, the FSM SHALL return to IDLE on the next cycle, without waiting for the end of the stop bit.
REQ-017 The push SHALL occur on the cycle after the STOP sample; DATA and COUNT SHALL reflect it one cycle later.
REQ-018 A pop SHALL occur on a cycle with CLK_CPU=1 and RD=1 and COUNT>0. RD while CLK_CPU=0 SHALL be ignored.
REQ-019 BYTE SHALL always show the FIFO head. VALID = (COUNT != 0). When empty, BYTE SHALL read 0x00.
REQ-020 Push while full without a pop SHALL drop the incoming byte, set OVF, and leave contents and COUNT unchanged.
REQ-021 Simultaneous push and pop when full: both SHALL succeed, COUNT unchanged, OVF not set.
REQ-022 Simultaneous push and pop when empty: the push SHALL succeed and the pop SHALL be ignored; COUNT becomes 1.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH. COUNT SHALL range 0..DEPTH and never wrap.
REQ-024 OVF and FERR SHALL be sticky. Both SHALL clear on any cycle with CLK_CPU=1 and RD=1, including when empty.
REQ-025 A flag-set event coinciding with a clear SHALL leave the flag set (set wins).
REQ-026 The bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reload on every state change.

Reset
REQ-027 RESET_N low SHALL immediately force: FSM=IDLE, pointers=0, COUNT=0, OVF=FERR=0, DATA=16'h0000.
REQ-028 Synchronizer flops SHALL reset to 1 so that reset release does not cause a false start.
REQ-029 Reset asserted mid-frame SHALL abandon the frame, with no partial push. Reception SHALL resume at the next falling edge after release.
REQ-030 FIFO storage contents need not be reset; they SHALL be unobservable while COUNT=0.

Verification (CLKS_PER_BIT=16, DEPTH=16)
REQ-031 Frame 0x55 with valid stop -> 2 cycles after STOP sample: DATA=16'h0155, COUNT=1. Then RD with CLK_CPU -> DATA=16'h0000, COUNT=0.
REQ-032 UART_RX low for 4 cycles, then high -> no push, COUNT=0, DATA=16'h0000, FSM back in IDLE.
REQ-033 Frame 0xA5 with stop bit low -> COUNT=0, DATA=16'h0400. RD+CLK_CPU -> DATA=16'h0000.
REQ-034 17 frames 0x00..0x10, no reads -> COUNT=16, DATA=16'h0300. One pop -> DATA=16'h0101, COUNT=15, OVF cleared.
REQ-035 Full FIFO; pop coincides with the 17th push -> COUNT=16, OVF=0, last entry=0x10.
REQ-036 RESET_N low during data bit 3 of a frame -> DATA=16'h0000 immediately. After release, frame 0x3C -> DATA=16'h013C, COUNT=1.
